// File: rtl/home_event_scheduler_if.sv
// Sensor inputs and actuator/display outputs of the home event scheduler.
// The slave modport is the scheduler side; the master modport is the environment side.
interface home_event_scheduler_if;
  logic       SFD;
  logic       SRD;
  logic       SFA;
  logic       SW;
  logic [7:0] ST;
  logic       fdoor;
  logic       rdoor;
  logic       alarmbuzz;
  logic       winbuzz;
  logic       cooler;
  logic       heater;
  logic [2:0] display;
  logic       busy;
  logic       overrun;

  modport master (
    output SFD, SRD, SFA, SW, ST,
    input  fdoor, rdoor, alarmbuzz, winbuzz, cooler, heater, display, busy, overrun
  );

  modport slave (
    input  SFD, SRD, SFA, SW, ST,
    output fdoor, rdoor, alarmbuzz, winbuzz, cooler, heater, display, busy, overrun
  );
endinterface

// File: rtl/home_event_scheduler.sv
// Home event scheduler: latches sensor events, serves actuators round-robin with a fixed dwell.
// Optional macro FIRE_PREEMPT_EN lets pending fire jump the queue and abort other services.
module home_event_scheduler #(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [7:0] T_LOW       = 8'd50,
  parameter logic [7:0] T_HIGH      = 8'd70
) (
  input logic                   clk,
  input logic                   Rst,
  home_event_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE, GAP} state_t;

  state_t     state, stateNext;
  logic [3:0] sens, prevSens, edges, grantMask, abortMask, pendNext;
  logic [4:0] pending;
  logic [2:0] last, cur, curNext, grantIdx, cand;
  logic [7:0] timer;
  logic       tempReq, coolNow, cool, coolNext, grantValid, abort, overrunNext, busyNext;
  logic [5:0] actNext;
  logic [2:0] dispNext;

  assign sens    = {bus.SW, bus.SFA, bus.SRD, bus.SFD};
  assign edges   = sens & ~prevSens;
  assign tempReq = (bus.ST < T_LOW) || (bus.ST > T_HIGH);
  assign coolNow = bus.ST > T_HIGH;

`ifdef FIRE_PREEMPT_EN
  // Abort only while dwell remains; on the final cycle the service has already completed.
  assign abort = (state == SERVE) && pending[2] && (cur != 3'd2) && (timer != 8'd0);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    grantValid = 1'b0;
    grantIdx   = 3'd0;
    cand       = 3'd0;
    for (int i = 1; i <= 5; i++) begin
      cand = 3'((int'(last) + i) % 5);
      if (!grantValid && pending[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
`ifdef FIRE_PREEMPT_EN
    if (pending[2]) begin
      grantValid = 1'b1;
      grantIdx   = 3'd2;
    end
`endif
  end

  // A fresh edge beats a same-cycle grant; an edge onto an untouched pending bit is a drop.
  always_comb begin
    grantMask = 4'd0;
    abortMask = 4'd0;
    if (state == IDLE && grantValid) grantMask = 4'b0001 << grantIdx;
    if (abort) abortMask = 4'b0001 << cur;
    pendNext    = (pending[3:0] & ~grantMask) | abortMask | edges;
    overrunNext = |(edges & pending[3:0] & ~grantMask);
  end

  always_ff @(posedge clk) begin
    if (Rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grantValid) stateNext = SERVE;
      SERVE:   if (timer == 8'd0 || abort) stateNext = GAP;
      GAP:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    curNext  = cur;
    coolNext = cool;
    if (state == IDLE && grantValid) begin
      curNext  = grantIdx;
      coolNext = coolNow;
    end
    actNext  = 6'd0;
    dispNext = 3'd0;
    busyNext = (stateNext != IDLE);
    if (stateNext == SERVE) begin
      dispNext = curNext + 3'd1;
      case (curNext)
        3'd0:    actNext = 6'b100000;
        3'd1:    actNext = 6'b010000;
        3'd2:    actNext = 6'b001000;
        3'd3:    actNext = 6'b000100;
        3'd4:    actNext = coolNext ? 6'b000010 : 6'b000001;
        default: actNext = 6'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      prevSens      <= 4'd0;
      pending       <= 5'd0;
      last          <= 3'd4;
      cur           <= 3'd0;
      cool          <= 1'b0;
      timer         <= 8'd0;
      bus.fdoor     <= 1'b0;
      bus.rdoor     <= 1'b0;
      bus.alarmbuzz <= 1'b0;
      bus.winbuzz   <= 1'b0;
      bus.cooler    <= 1'b0;
      bus.heater    <= 1'b0;
      bus.display   <= 3'd0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      prevSens <= sens;
      pending  <= {tempReq, pendNext};
      cur      <= curNext;
      cool     <= coolNext;
      if (state == IDLE && grantValid) begin
        last  <= grantIdx;
        timer <= 8'(HOLD_CYCLES - 1);
      end else if (state == SERVE && timer != 8'd0) begin
        timer <= timer - 8'd1;
      end
      bus.fdoor     <= actNext[5];
      bus.rdoor     <= actNext[4];
      bus.alarmbuzz <= actNext[3];
      bus.winbuzz   <= actNext[2];
      bus.cooler    <= actNext[1];
      bus.heater    <= actNext[0];
      bus.display   <= dispNext;
      bus.busy      <= busyNext;
      bus.overrun   <= overrunNext;
    end
  end
endmodule

// File: doc/home_event_scheduler.md
Name: home_event_scheduler

Overview:
- Sequences the home actuators (front/rear door, fire alarm buzzer, window buzzer, cooler/heater) from sensor events.
- Latches each sensor event as a pending request.
- Grants requesters one at a time, round-robin, and holds each granted actuator on for a fixed dwell time.
- Sits between the raw sensor inputs and the actuator/display outputs; it is the only block that drives the actuators.

Parameters:
- HOLD_CYCLES, 4: cycles a granted actuator output stays high. Legal range 1..255.
- T_LOW, 50: temperature strictly below this requests the heater.
- T_HIGH, 70: temperature strictly above this requests the cooler.

Ports:
- clk  in  1  clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- SFD  in  1  front door sensor, level
- SRD  in  1  rear door sensor, level
- SFA  in  1  fire alarm sensor, level
- SW   in  1  window sensor, level
- ST   in  8  temperature, unsigned
- fdoor, rdoor, alarmbuzz, winbuzz, cooler, heater  out  1 each  registered actuator drives
- display  out  3  registered code of the requester being served
- busy  out  1  high in SERVE and GAP
- overrun  out  1  one-cycle pulse when an event is dropped

Behaviour:
- Requester indices and display codes:
  - 0 front (display 1), 1 rear (2), 2 fire (3), 3 window (4), 4 temp (5).
  - display is 0 whenever nothing is being served.
- Reset:
  - All outputs 0, pending 0, state IDLE, timer 0.
  - Round-robin pointer last=4, so the first search starts at index 0.
  - Edge-detect registers reset to 0, so a sensor already high when Rst deasserts counts as an event.
- Pending, indices 0-3:
  - Set on a sampled rising edge of the sensor (current 1, previous-sample 0).
  - Cleared on the cycle that requester is granted.
  - If an edge and a grant of the same index coincide, set wins and the request stays pending.
  - An edge while pending is already 1 (and not being granted) is dropped and pulses overrun for 1 cycle. Multiple simultaneous drops produce a single pulse.
- Pending, index 4 (temp):
  - Level request: pending = (ST<T_LOW) or (ST>T_HIGH), evaluated every cycle. Never overruns.
  - ST equal to T_LOW or T_HIGH is in band, so no request.
- FSM states: IDLE, SERVE, GAP.
  - IDLE, pending==0: stay in IDLE; all actuators 0, display 0.
  - IDLE, pending!=0: pick the first pending index searching last+1, last+2, ... modulo 5.
    - Set last=index, clear its pending bit, load timer=HOLD_CYCLES-1, go to SERVE.
    - Outputs for the grant appear after this edge.
  - SERVE: exactly one actuator high, display = code.
    - Temp grant: cooler if ST>T_HIGH at the grant edge, else heater. The choice is frozen for the whole service, even if ST returns to band.
    - Timer decrements each cycle; when timer==0, go to GAP at the next edge.
  - GAP: all actuators 0, display 0, busy 1. Exactly 1 cycle, then IDLE.
- Timing:
  - Actuator is high for exactly HOLD_CYCLES cycles.
  - Between back-to-back services, outputs are low for exactly 2 cycles (GAP + IDLE).
  - Latency from a sensor rising at edge k (idle system): pending after edge k, actuator high after edge k+1.
- Timer width is 8 bits; no wrap is possible within the legal HOLD_CYCLES range.
- Reset mid-SERVE or mid-GAP: outputs drop on the reset edge and pending is lost.

Optional Feature:
- Macro: FIRE_PREEMPT_EN.
- Defined:
  - In IDLE, pending fire (index 2) wins over round-robin order; last is still updated to 2.
  - In SERVE of another index, pending fire aborts the service: go to GAP on the next edge, and re-set the aborted requester's pending bit (temp re-evaluates by level).
  - A fire service itself is never aborted.
- Undefined: pure round-robin, no abort; fire waits its turn.

Test Plan:
- Rst, then SFD 0→1 → fdoor=1, display=1 from 2 cycles after the edge for 4 cycles; then 2 cycles all-0; busy=1 during SERVE+GAP.
- SFD, SRD, SW rise in the same cycle → grants in order front, rear, window; each output high 4 cycles, with 2 off cycles between.
- ST=80 → cooler=1, display=5. ST=40 → heater=1. ST=50 or ST=70 → no grant. ST changes 80→60 mid-service → cooler stays high all 4 cycles.
- During front service, SFD falls and rises again → front re-pends, overrun stays 0. A second rise before service → overrun=1 for 1 cycle.
- FIRE_PREEMPT_EN defined, SW served, SFA rises at service cycle 1 → winbuzz drops next cycle, alarmbuzz serves 4 cycles, then winbuzz serves again. Undefined → window completes 4 cycles first.
- Rst asserted mid-SERVE with pending bits set → all outputs 0 next cycle. After release, a sensor held high is treated as a new event and served.
